cable_sensor_fe: RTL and testbench

CABLE_SENSOR_FE -- requirements
Module: cable_sensor_fe

---
 rtl/cable_pkg.sv | 19 +
 rtl/cable_debounce.sv | 53 +++++
 rtl/cable_sensor_fe.sv | 130 +++++++++++++
 tb/tb_cable_sensor_fe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cable_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cable_pkg -- FSM state type and shared constants for cable_sensor_fe
// Revision: 1.0
// ------------------------------------------------------------------
package cable_pkg;

  localparam int ACC_W      = 12;
  localparam int ACC_TO_CYC = 64;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cable_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// cable_debounce -- accepts a new level after DEB_CYC equal samples
// Revision: 1.0
// ------------------------------------------------------------------
module cable_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  input  logic sync_i,
  output logic stable_o
);

  localparam int            CW     = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // Counter stops at C_LAST: the level is accepted there and the count restarts.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (clr_i) begin
      cnt_d    = '0;
      stable_d = 1'b0;
    end else if (!en_i || (sync_i == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == C_LAST) begin
      cnt_d    = '0;
      stable_d = sync_i;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule
`default_nettype wire

// File: rtl/cable_sensor_fe.sv
`default_nettype none
// ------------------------------------------------------------------
// cable_sensor_fe -- cable-presence sensor and accelerometer front end
// Optional macro CABLE_ACC_TIMEOUT_EN adds the accelerometer timeout fault.
// Revision: 1.0
// ------------------------------------------------------------------
module cable_sensor_fe
  import cable_pkg::*;
#(
  parameter int               SETTLE_CYC = 8,
  parameter int               DEB_CYC    = 4,
  parameter logic [ACC_W-1:0] ACC_THRESH = 12'd2048
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_sensor,
  input  logic             en_acc,
  input  logic             en_clamp,
  input  logic             sens_raw,
  input  logic             acc_valid,
  input  logic [ACC_W-1:0] acc_data,
  output logic             acc_ready,
  output logic             sensor_pwr,
  output logic             detect,
  output logic             flag,
  output logic             fault
);

  localparam int            SW            = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] C_SETTLE_LAST = SW'(SETTLE_CYC - 1);

  logic          sync1_q, sync2_q;
  state_e        state_q;
  logic [SW-1:0] settle_cnt_q;
  logic          sensor_pwr_q;
  logic          flag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sens_raw;
      sync2_q <= sync1_q;
    end
  end

  assign acc_ready = (state_q == RUN) && en_acc;

  // Dropping en_sensor wins over everything except reset, from any state.
  always_ff @(posedge clk) begin
    if (reset || !en_sensor) begin
      state_q      <= OFF;
      settle_cnt_q <= '0;
      sensor_pwr_q <= 1'b0;
      flag_q       <= 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          state_q      <= SETTLE;
          settle_cnt_q <= '0;
          sensor_pwr_q <= 1'b1;
        end
        SETTLE: begin
          if (settle_cnt_q == C_SETTLE_LAST) begin
            state_q      <= RUN;
            settle_cnt_q <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (en_clamp) state_q <= HOLD;
          if (!en_acc) begin
            flag_q <= 1'b0;
          end else if (acc_valid) begin
            flag_q <= (acc_data >= ACC_THRESH);
          end
        end
        HOLD: begin
          if (!en_clamp) state_q <= RUN;
        end
        default: state_q <= OFF;
      endcase
    end
  end

  cable_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (!en_sensor),
    .en_i     (state_q == RUN),
    .sync_i   (sync2_q),
    .stable_o (detect)
  );

  assign sensor_pwr = sensor_pwr_q;

`ifdef CABLE_ACC_TIMEOUT_EN
  localparam int            TW        = $clog2(ACC_TO_CYC);
  localparam logic [TW-1:0] C_TO_LAST = TW'(ACC_TO_CYC - 1);

  logic [TW-1:0] to_cnt_q;
  logic          fault_q;

  // Fault latches after ACC_TO_CYC idle ready cycles; the counter then sits at its top.
  always_ff @(posedge clk) begin
    if (reset || !en_sensor) begin
      to_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else if (!acc_ready || acc_valid) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q == C_TO_LAST) begin
      fault_q <= 1'b1;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign fault = fault_q;
  assign flag  = flag_q | fault_q;
`else
  assign fault = 1'b0;
  assign flag  = flag_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cable_sensor_fe.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cable_sensor_fe -- directed self-checking bench for cable_sensor_fe
// Revision: 1.0
// ------------------------------------------------------------------
module tb_cable_sensor_fe;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        en_sensor = 1'b0;
  logic        en_acc    = 1'b0;
  logic        en_clamp  = 1'b0;
  logic        sens_raw  = 1'b0;
  logic        acc_valid = 1'b0;
  logic [11:0] acc_data  = 12'd0;
  logic        acc_ready, sensor_pwr, detect, flag, fault;

  int checks = 0;
  int errors = 0;

`ifdef CABLE_ACC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  cable_sensor_fe #(
    .SETTLE_CYC (8),
    .DEB_CYC    (4),
    .ACC_THRESH (12'd2048)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en_sensor  (en_sensor),
    .en_acc     (en_acc),
    .en_clamp   (en_clamp),
    .sens_raw   (sens_raw),
    .acc_valid  (acc_valid),
    .acc_data   (acc_data),
    .acc_ready  (acc_ready),
    .sensor_pwr (sensor_pwr),
    .detect     (detect),
    .flag       (flag),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; en_sensor = 1'b1; en_acc = 1'b1;
    tick(3);
    checks++; if (sensor_pwr !== 1'b0) begin errors++; $display("FAIL reset_pwr: got %b expected 0", sensor_pwr); end
    checks++; if (detect !== 1'b0) begin errors++; $display("FAIL reset_detect: got %b expected 0", detect); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected 0", flag); end
    checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", acc_ready); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
    en_sensor = 1'b0; en_acc = 1'b0;
  endtask

  task automatic test_settle;
    reset = 1'b0; en_sensor = 1'b1; en_acc = 1'b1;
    tick(1);
    checks++; if (sensor_pwr !== 1'b1) begin errors++; $display("FAIL settle_pwr: got %b expected 1", sensor_pwr); end
    checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL settle_ready_early: got %b expected 0", acc_ready); end
    tick(7);
    checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL settle_ready_last: got %b expected 0", acc_ready); end
    tick(1);
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL settle_run: got %b expected 1", acc_ready); end
    checks++; if (detect !== 1'b0) begin errors++; $display("FAIL settle_detect: got %b expected 0", detect); end
    en_acc = 1'b0;
  endtask

  task automatic test_debounce;
    bit ok;
    sens_raw = 1'b1;
    tick(5);
    checks++; if (detect !== 1'b0) begin errors++; $display("FAIL deb_early: got %b expected 0", detect); end
    tick(1);
    checks++; if (detect !== 1'b1) begin errors++; $display("FAIL deb_rise: got %b expected 1", detect); end
    sens_raw = 1'b0;
    tick(3);
    sens_raw = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (detect !== 1'b1) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL deb_glitch: held=%b expected 1", ok); end
  endtask

  task automatic test_flag;
    en_acc = 1'b1; acc_valid = 1'b1; acc_data = 12'd2048;
    #1;
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL flag_ready: got %b expected 1", acc_ready); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL flag_pre: got %b expected 0", flag); end
    tick(1);
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL flag_2048: got %b expected 1", flag); end
    acc_data = 12'd2047;
    tick(1);
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL flag_2047: got %b expected 0", flag); end
    acc_data = 12'd4095;
    tick(1);
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL flag_4095: got %b expected 1", flag); end
    acc_valid = 1'b0; acc_data = 12'd0;
    tick(2);
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL flag_hold_novalid: got %b expected 1", flag); end
    en_acc = 1'b0; acc_valid = 1'b1; acc_data = 12'd4095;
    #1;
    checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL flag_ready_off: got %b expected 0", acc_ready); end
    tick(1);
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL flag_en_acc_clear: got %b expected 0", flag); end
    en_acc = 1'b1;
    tick(1);
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL flag_reenable: got %b expected 1", flag); end
    acc_valid = 1'b0;
  endtask

  task automatic test_clamp_hold;
    bit ok_det, ok_flag, ok_rdy;
    en_clamp = 1'b1; sens_raw = 1'b0;
    tick(1);
    checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b expected 0", acc_ready); end
    acc_valid = 1'b1; acc_data = 12'd0;
    ok_det = 1'b1; ok_flag = 1'b1; ok_rdy = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tick(1);
      if (detect !== 1'b1) ok_det = 1'b0;
      if (flag !== 1'b1) ok_flag = 1'b0;
      if (acc_ready !== 1'b0) ok_rdy = 1'b0;
    end
    checks++; if (ok_det !== 1'b1) begin errors++; $display("FAIL hold_detect: held=%b expected 1", ok_det); end
    checks++; if (ok_flag !== 1'b1) begin errors++; $display("FAIL hold_flag: held=%b expected 1", ok_flag); end
    checks++; if (ok_rdy !== 1'b1) begin errors++; $display("FAIL hold_ready_low: held=%b expected 1", ok_rdy); end
    acc_valid = 1'b0; en_clamp = 1'b0;
    tick(4);
    checks++; if (detect !== 1'b1) begin errors++; $display("FAIL release_detect_early: got %b expected 1", detect); end
    tick(1);
    checks++; if (detect !== 1'b0) begin errors++; $display("FAIL release_detect_fall: got %b expected 0", detect); end
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL release_flag: got %b expected 1", flag); end
  endtask

  task automatic test_off_from_hold;
    acc_valid = 1'b1; acc_data = 12'd4095; sens_raw = 1'b1;
    tick(1);
    acc_valid = 1'b0;
    tick(7);
    checks++; if (detect !== 1'b1) begin errors++; $display("FAIL off_pre_detect: got %b expected 1", detect); end
    en_clamp = 1'b1;
    tick(3);
    en_sensor = 1'b0;
    tick(1);
    checks++; if (sensor_pwr !== 1'b0) begin errors++; $display("FAIL off_pwr: got %b expected 0", sensor_pwr); end
    checks++; if (detect !== 1'b0) begin errors++; $display("FAIL off_detect: got %b expected 0", detect); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL off_flag: got %b expected 0", flag); end
    checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL off_ready: got %b expected 0", acc_ready); end
    en_clamp = 1'b0; sens_raw = 1'b0; en_acc = 1'b0;
  endtask

  task automatic test_clamp_in_settle;
    en_clamp = 1'b1; en_acc = 1'b1; en_sensor = 1'b1;
    tick(9);
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL clamp_settle_run: got %b expected 1", acc_ready); end
    tick(1);
    checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL clamp_settle_hold: got %b expected 0", acc_ready); end
    en_sensor = 1'b0; en_clamp = 1'b0; en_acc = 1'b0;
    tick(1);
    checks++; if (sensor_pwr !== 1'b0) begin errors++; $display("FAIL clamp_settle_off: got %b expected 0", sensor_pwr); end
  endtask

  task automatic test_timeout;
    en_sensor = 1'b1;
    tick(9);
    en_acc = 1'b1; acc_valid = 1'b0;
    tick(63);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_fault_early: got %b expected 0", fault); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL to_flag_early: got %b expected 0", flag); end
    tick(1);
    checks++; if (fault !== TO_EN) begin errors++; $display("FAIL to_fault: got %b expected %b", fault, TO_EN); end
    checks++; if (flag !== TO_EN) begin errors++; $display("FAIL to_flag: got %b expected %b", flag, TO_EN); end
    tick(5);
    checks++; if (fault !== TO_EN) begin errors++; $display("FAIL to_fault_sticky: got %b expected %b", fault, TO_EN); end
    en_sensor = 1'b0;
    tick(1);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_fault_off: got %b expected 0", fault); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL to_flag_off: got %b expected 0", flag); end
    en_acc = 1'b0;
  endtask

  task automatic test_reset_mid;
    en_sensor = 1'b1; en_acc = 1'b1; sens_raw = 1'b1;
    tick(16);
    acc_valid = 1'b1; acc_data = 12'd4095;
    tick(1);
    checks++; if (detect !== 1'b1) begin errors++; $display("FAIL mid_pre_detect: got %b expected 1", detect); end
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL mid_pre_flag: got %b expected 1", flag); end
    reset = 1'b1;
    tick(1);
    checks++; if (sensor_pwr !== 1'b0) begin errors++; $display("FAIL mid_pwr: got %b expected 0", sensor_pwr); end
    checks++; if (detect !== 1'b0) begin errors++; $display("FAIL mid_detect: got %b expected 0", detect); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL mid_flag: got %b expected 0", flag); end
    checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", acc_ready); end
    reset = 1'b0; en_sensor = 1'b0; en_acc = 1'b0; acc_valid = 1'b0; sens_raw = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_settle();
    test_debounce();
    test_flag();
    test_clamp_hold();
    test_off_from_hold();
    test_clamp_in_settle();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
